wbm_cmd_master: RTL and testbench

//  Wishbone initiator (single classic cycles) that drives the master port of the wbs_arbiter.

---
 rtl/wbm_cmd_master.sv | 205 ++++++++++++++++++++
 tb/tb_wbm_cmd_master.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wbm_cmd_master.sv
// Single-cycle classic Wishbone initiator bridging a valid/ready command port to the bus.
// Optional macro WBM_CMD_TIMEOUT_EN enables the TIMEOUT abort; otherwise BUS waits for ack/err.
module wbm_cmd_master #(
  parameter int unsigned TIMEOUT  = 10,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [3:0]  cmd_sel_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        rsp_tout_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic        accept_s;
  logic        bus_err_s;
  logic        bus_ack_s;
  logic        timeout_s;
  logic        rsp_done_s;
  logic        cmd_ready_s;
  logic        cyc_s;
  logic        we_s;
  logic [3:0]  sel_s;
  logic [31:0] adr_s;
  logic [31:0] dat_s;
  logic        rsp_valid_s;
  logic [31:0] rsp_dat_s;
  logic        rsp_err_s;
  logic        rsp_tout_s;

  if (TIMEOUT < 32'd1) begin : g_bad_timeout
    $error("wbm_cmd_master: TIMEOUT must be >= 1");
  end

  assign accept_s   = cmd_valid_i & cmd_ready_o;
  assign bus_err_s  = wbm_cyc_o & wbm_err_i;
  assign bus_ack_s  = wbm_cyc_o & wbm_ack_i;
  assign rsp_done_s = rsp_valid_o & rsp_ready_i;

`ifdef WBM_CMD_TIMEOUT_EN
  localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_r;

  // Cycles spent in BUS without a response; saturates instead of wrapping.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (state_r != ST_BUS) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_r != CNT_MAX) begin
      cnt_r <= cnt_r + CNT_W'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign timeout_s = wbm_cyc_o & (cnt_r == CNT_LAST);
`else
  assign timeout_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; err, ack and timeout all end the bus cycle.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_next_s = ST_BUS;
        else          state_next_s = ST_IDLE;
      end
      ST_BUS: begin
        if (bus_err_s | bus_ack_s | timeout_s) state_next_s = ST_RESP;
        else                                    state_next_s = ST_BUS;
      end
      ST_RESP: begin
        if (rsp_done_s) state_next_s = ST_IDLE;
        else            state_next_s = ST_RESP;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; err outranks ack, which outranks timeout.
  always_comb begin
    cmd_ready_s = (state_next_s == ST_IDLE);
    cyc_s       = wbm_cyc_o;
    we_s        = wbm_we_o;
    sel_s       = wbm_sel_o;
    adr_s       = wbm_adr_o;
    dat_s       = wbm_dat_o;
    rsp_valid_s = rsp_valid_o;
    rsp_dat_s   = rsp_dat_o;
    rsp_err_s   = rsp_err_o;
    rsp_tout_s  = rsp_tout_o;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          cyc_s = 1'b1;
          we_s  = cmd_we_i;
          sel_s = cmd_sel_i;
          adr_s = cmd_adr_i;
          dat_s = cmd_dat_i;
        end else begin
          cyc_s = 1'b0;
        end
      end
      ST_BUS: begin
        if (bus_err_s) begin
          cyc_s       = 1'b0;
          rsp_valid_s = 1'b1;
          rsp_err_s   = 1'b1;
          rsp_tout_s  = 1'b0;
          rsp_dat_s   = ERR_DATA;
        end else if (bus_ack_s) begin
          cyc_s       = 1'b0;
          rsp_valid_s = 1'b1;
          rsp_err_s   = 1'b0;
          rsp_tout_s  = 1'b0;
          rsp_dat_s   = wbm_we_o ? 32'h0000_0000 : wbm_dat_i;
        end else if (timeout_s) begin
          cyc_s       = 1'b0;
          rsp_valid_s = 1'b1;
          rsp_err_s   = 1'b1;
          rsp_tout_s  = 1'b1;
          rsp_dat_s   = ERR_DATA;
        end else begin
          cyc_s = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_done_s) rsp_valid_s = 1'b0;
        else            rsp_valid_s = 1'b1;
      end
      default: begin
        cyc_s       = 1'b0;
        rsp_valid_s = 1'b0;
      end
    endcase
  end

  // Output registers; stb always mirrors cyc.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cmd_ready_o <= 1'b0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_sel_o   <= 4'h0;
      wbm_adr_o   <= 32'h0000_0000;
      wbm_dat_o   <= 32'h0000_0000;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= 32'h0000_0000;
      rsp_err_o   <= 1'b0;
      rsp_tout_o  <= 1'b0;
    end else begin
      cmd_ready_o <= cmd_ready_s;
      wbm_cyc_o   <= cyc_s;
      wbm_stb_o   <= cyc_s;
      wbm_we_o    <= we_s;
      wbm_sel_o   <= sel_s;
      wbm_adr_o   <= adr_s;
      wbm_dat_o   <= dat_s;
      rsp_valid_o <= rsp_valid_s;
      rsp_dat_o   <= rsp_dat_s;
      rsp_err_o   <= rsp_err_s;
      rsp_tout_o  <= rsp_tout_s;
    end
  end

endmodule

// File: tb/tb_wbm_cmd_master.sv
// Randomized bench for wbm_cmd_master: a transaction-level model sets per-cycle expectations,
// one negedge process compares them; directed cases pin cycle counts and response values.
module tb_wbm_cmd_master;

  localparam int          TO = 10;
  localparam logic [31:0] ED = 32'hDEADBEEF;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [3:0]  cmd_sel_i;
  logic [31:0] cmd_adr_i, cmd_dat_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o, rsp_tout_o;
  logic [31:0] rsp_dat_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic        wbm_ack_i, wbm_err_i;

  wbm_cmd_master #(.TIMEOUT(TO), .ERR_DATA(ED)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_sel_i(cmd_sel_i), .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
    .rsp_err_o(rsp_err_o), .rsp_tout_o(rsp_tout_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int checks   = 0;
  int failures = 0;

  // Expectations for the outputs following the most recent rising edge.
  logic        chk_en = 1'b0, exp_zero = 1'b0;
  logic        exp_cmd_ready, exp_cyc, exp_we, exp_rsp_valid, exp_rsp_err, exp_rsp_tout;
  logic [3:0]  exp_sel;
  logic [31:0] exp_adr, exp_dat, exp_rsp_dat;

  int          cyc_run = 0, last_cyc_len = 0;
  logic        last_err, last_tout;
  logic [31:0] last_dat;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge wb_clk_i) begin
    if (chk_en) begin
      chk("cmd_ready", 32'(cmd_ready_o), 32'(exp_cmd_ready));
      chk("cyc", 32'(wbm_cyc_o), 32'(exp_cyc));
      chk("stb", 32'(wbm_stb_o), 32'(exp_cyc));
      chk("rsp_valid", 32'(rsp_valid_o), 32'(exp_rsp_valid));
      if (exp_cyc) begin
        chk("wbm_we", 32'(wbm_we_o), 32'(exp_we));
        chk("wbm_sel", 32'(wbm_sel_o), 32'(exp_sel));
        chk("wbm_adr", wbm_adr_o, exp_adr);
        chk("wbm_dat", wbm_dat_o, exp_dat);
      end
      if (exp_rsp_valid) begin
        chk("rsp_err", 32'(rsp_err_o), 32'(exp_rsp_err));
        chk("rsp_tout", 32'(rsp_tout_o), 32'(exp_rsp_tout));
        chk("rsp_dat", rsp_dat_o, exp_rsp_dat);
      end
      if (exp_zero) begin
        chk("rst_fields", {wbm_sel_o, 3'd0, wbm_we_o, 3'd0, rsp_err_o, 3'd0, rsp_tout_o, 16'd0},
            32'd0);
        chk("rst_adr", wbm_adr_o, 32'd0);
        chk("rst_dat", wbm_dat_o, 32'd0);
        chk("rst_rsp_dat", rsp_dat_o, 32'd0);
      end
    end
    if (wbm_cyc_o === 1'b1) begin
      cyc_run++;
    end else if (cyc_run > 0) begin
      last_cyc_len = cyc_run;
      cyc_run      = 0;
    end
    if (rsp_valid_o === 1'b1) begin
      last_err  = rsp_err_o;
      last_tout = rsp_tout_o;
      last_dat  = rsp_dat_o;
    end
  end

  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  // Response rules: where the cycle ends (cycle index after accept) and what it returns.
  task automatic model_rsp(input logic we, input int kind, input int lat, input logic [31:0] rdat,
                           output int end_k, output logic e, output logic t, output logic [31:0] d);
    end_k = lat;
    t     = 1'b0;
`ifdef WBM_CMD_TIMEOUT_EN
    if (lat > TO) begin
      end_k = TO;
      t     = 1'b1;
    end
`endif
    if (t || kind != 0) begin
      e = 1'b1;
      d = ED;
    end else begin
      e = 1'b0;
      d = we ? 32'd0 : rdat;
    end
  endtask

  // kind: 0 = ack, 1 = err, 2 = err+ack together; lat = cyc cycle carrying the response.
  task automatic do_txn(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [31:0] rdat, input int kind,
                        input int lat, input int rdly);
    int end_k;
    logic e, t;
    logic [31:0] d;
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_sel_i = sel; cmd_adr_i = adr; cmd_dat_i = dat;
    wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
    step();
    exp_cyc = 1'b1; exp_we = we; exp_sel = sel; exp_adr = adr; exp_dat = dat;
    exp_cmd_ready = 1'b0; exp_rsp_valid = 1'b0; exp_zero = 1'b0;
    model_rsp(we, kind, lat, rdat, end_k, e, t, d);
    for (int k = 1; k <= end_k; k++) begin
      cmd_valid_i = 1'($urandom_range(0, 1));
      cmd_we_i = 1'($urandom_range(0, 1)); cmd_adr_i = $urandom; cmd_dat_i = $urandom;
      rsp_ready_i = 1'($urandom_range(0, 1));
      wbm_dat_i = (k == lat) ? rdat : $urandom;
      wbm_ack_i = (k == lat) && (kind != 1);
      wbm_err_i = (k == lat) && (kind != 0);
      step();
      if (k == end_k) begin
        exp_cyc = 1'b0; exp_rsp_valid = 1'b1;
        exp_rsp_err = e; exp_rsp_tout = t; exp_rsp_dat = d;
      end
    end
    for (int i = 0; i < rdly; i++) begin
      rsp_ready_i = 1'b0;
      cmd_valid_i = 1'($urandom_range(0, 1)); cmd_adr_i = $urandom;
      wbm_ack_i = 1'($urandom_range(0, 1)); wbm_err_i = 1'($urandom_range(0, 1));
      wbm_dat_i = $urandom;
      step();
    end
    rsp_ready_i = 1'b1;
    step();
    exp_rsp_valid = 1'b0; exp_cmd_ready = 1'b1;
    rsp_ready_i = 1'b0; cmd_valid_i = 1'b0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
  endtask

  initial begin
    int gap, lat, kind, r;
    wb_rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_sel_i = 4'h0;
    cmd_adr_i = 32'd0; cmd_dat_i = 32'd0; rsp_ready_i = 1'b0;
    wbm_dat_i = 32'd0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
    step();
    chk_en = 1'b1; exp_zero = 1'b1;
    exp_cmd_ready = 1'b0; exp_cyc = 1'b0; exp_rsp_valid = 1'b0;
    step();
    wb_rst_i = 1'b0;
    step();
    exp_zero = 1'b0; exp_cmd_ready = 1'b1;
    step();

    do_txn(1'b1, 4'hF, 32'h0000_1000, 32'hCAFEF00D, 32'h0BAD_0BAD, 0, 3, 0);
    chk("t1_cyc_len", 32'(last_cyc_len), 32'd3);
    chk("t1_rsp_dat", last_dat, 32'd0);
    chk("t1_rsp_err", 32'(last_err), 32'd0);

    do_txn(1'b0, 4'hF, 32'h0000_0040, 32'd0, 32'h12345678, 0, 1, 0);
    chk("t2_cyc_len", 32'(last_cyc_len), 32'd1);
    chk("t2_rsp_dat", last_dat, 32'h12345678);

    do_txn(1'b0, 4'h3, 32'h0000_0080, 32'd0, 32'h55AA_55AA, 2, 2, 1);
    chk("t3_rsp_err", 32'(last_err), 32'd1);
    chk("t3_rsp_tout", 32'(last_tout), 32'd0);
    chk("t3_rsp_dat", last_dat, 32'hDEADBEEF);

    do_txn(1'b0, 4'hF, 32'h0000_0100, 32'd0, 32'hA5A5_A5A5, 0, 120, 0);
`ifdef WBM_CMD_TIMEOUT_EN
    chk("t4_cyc_len", 32'(last_cyc_len), 32'd10);
    chk("t4_rsp_tout", 32'(last_tout), 32'd1);
    chk("t4_rsp_dat", last_dat, 32'hDEADBEEF);
`else
    chk("t4_cyc_len", 32'(last_cyc_len), 32'd120);
    chk("t4_rsp_err", 32'(last_err), 32'd0);
    chk("t4_rsp_dat", last_dat, 32'hA5A5_A5A5);
`endif

    do_txn(1'b1, 4'h5, 32'h0000_0200, 32'h1111_2222, 32'd0, 0, 2, 5);
    chk("t5_rsp_dat", last_dat, 32'd0);

    // Reset for one cycle in the middle of a bus cycle, with a stray ack around it.
    cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_sel_i = 4'hF;
    cmd_adr_i = 32'h0000_0300; cmd_dat_i = 32'h0000_1234;
    step();
    exp_cyc = 1'b1; exp_we = 1'b1; exp_sel = 4'hF; exp_adr = 32'h0000_0300;
    exp_dat = 32'h0000_1234; exp_cmd_ready = 1'b0; exp_rsp_valid = 1'b0;
    cmd_valid_i = 1'b0;
    step();
    wb_rst_i = 1'b1; wbm_ack_i = 1'b1;
    step();
    exp_cyc = 1'b0; exp_cmd_ready = 1'b0; exp_rsp_valid = 1'b0; exp_zero = 1'b1;
    wb_rst_i = 1'b0;
    step();
    exp_zero = 1'b0; exp_cmd_ready = 1'b1;
    wbm_ack_i = 1'b0;
    step();
    do_txn(1'b0, 4'hC, 32'h0000_0400, 32'd0, 32'h7777_8888, 0, 2, 0);
    chk("t6_rsp_dat", last_dat, 32'h7777_8888);

    for (int n = 0; n < 40; n++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        cmd_valid_i = 1'b0;
        wbm_ack_i = 1'($urandom_range(0, 1)); wbm_err_i = 1'($urandom_range(0, 1));
        step();
      end
`ifdef WBM_CMD_TIMEOUT_EN
      lat = $urandom_range(1, TO + 3);
`else
      lat = $urandom_range(1, 8);
`endif
      r    = $urandom_range(0, 3);
      kind = (r < 2) ? 0 : r - 1;
      do_txn(1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom, $urandom,
             kind, lat, $urandom_range(0, 4));
    end

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
